rr_arbiter: RTL and testbench

Round-robin arbiter granting one of `CLIENTS` requesters per cycle, with rotating priority so every held request is served within `CLIENTS` cycles. It sits between a set of independent requesters and a single shared resource. The shared resource can pause all arbitration through `stall`. Grant is combinational from the current request vector and a registered priority pointer.

---
 rtl/rr_arbiter_pkg.sv | 11 +
 rtl/rr_arbiter_fixed_prio.sv | 23 ++
 rtl/rr_arbiter.sv | 73 +++++++
 tb/tb_rr_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin arbiter.
package rr_arbiter_pkg;

  localparam int RR_DEFAULT_CLIENTS = 32;

  // Pointer width for n clients, never narrower than one bit.
  function automatic int rr_ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_fixed_prio.sv
// Lowest-index-first priority picker: one-hot of the least significant set
// bit of req_i, or zero when req_i is zero.
module rr_fixed_prio #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !found) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer and combinational grant.
// Define RR_ARBITER_ASSERT_EN to compile the embedded SVA checks.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int CLIENTS = RR_DEFAULT_CLIENTS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [CLIENTS-1:0] request,
  input  logic               stall,
  output logic [CLIENTS-1:0] grant
);

  localparam int PW = rr_ptr_w(CLIENTS);

  logic [PW-1:0]      ptr_q, ptr_d, idx, idx_nxt;
  logic [CLIENTS-1:0] mask, masked_gnt, full_gnt, sel;

  // Clients at or above the pointer are searched first; the unmasked picker
  // supplies the wrapped-around winner when none of them is requesting.
  always_comb begin
    mask = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      mask[i] = (i >= int'(ptr_q));
    end
  end

  rr_fixed_prio #(.N(CLIENTS)) u_prio_masked (
    .req_i (request & mask),
    .gnt_o (masked_gnt)
  );

  rr_fixed_prio #(.N(CLIENTS)) u_prio_full (
    .req_i (request),
    .gnt_o (full_gnt)
  );

  assign sel   = (|masked_gnt) ? masked_gnt : full_gnt;
  assign grant = (reset || stall) ? '0 : sel;

  // sel is one-hot or zero, so OR-ing indices is a valid encoder.
  always_comb begin
    idx = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      if (sel[i]) idx = idx | PW'(i);
    end
  end

  always_comb begin
    idx_nxt = (int'(idx) == CLIENTS - 1) ? '0 : idx + PW'(1);
    ptr_d   = (|grant) ? idx_nxt : ptr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

`ifdef RR_ARBITER_ASSERT_EN
  a_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(grant));
  a_no_spurious: assert property (@(posedge clock) disable iff (reset)
    (grant & ~request) == '0);
  a_stall_quiet: assert property (@(posedge clock) disable iff (reset)
    stall |-> (grant == '0));
  a_work_conserving: assert property (@(posedge clock) disable iff (reset)
    (!stall && (request != '0)) |-> (grant != '0));
`else
  // Checks are compiled out; the arbitration logic above is unchanged.
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: a modular-arithmetic reference model pushes
// the expected grant per cycle, and a monitor compares on the falling edge.
module tb_rr_arbiter;

  localparam int N = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         stall;
  logic [N-1:0] request;
  logic [N-1:0] grant;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] exp_q[$];
  string        tag_q[$];
  int           mptr;
  int           wait_cnt[N];
  logic         rst_seen_q[$];

  rr_arbiter #(.CLIENTS(N)) dut (
    .clock   (clock),
    .reset   (reset),
    .request (request),
    .stall   (stall),
    .grant   (grant)
  );

  always #5 clock = ~clock;

  // Reference: walk clients ptr, ptr+1, ... mod N; first requester wins.
  function automatic int model_idx(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic s, input logic rst,
                       input string tag, output logic [N-1:0] exp);
    int w;
    request = r;
    stall   = s;
    reset   = rst;
    exp = '0;
    w = model_idx(r, mptr);
    if (!rst && !s && w >= 0) exp[w] = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    rst_seen_q.push_back(rst);
    if (rst)           mptr = 0;
    else if (exp != 0) mptr = (w + 1) % N;
    @(posedge clock);
    #1;
  endtask

  // Monitor: pops one expectation per cycle and tracks per-client waiting.
  initial begin
    logic [N-1:0] e;
    string        t;
    logic         r;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        r = rst_seen_q.pop_front();
        total++;
        if (grant !== e) begin
          bad++;
          $display("FAIL %s: grant=%h expected=%h", t, grant, e);
        end
        for (int i = 0; i < N; i++) begin
          if (r || !request[i] || grant[i]) wait_cnt[i] = 0;
          else if (!stall)                  wait_cnt[i]++;
        end
        for (int i = 0; i < N; i++) begin
          if (request[i] && !grant[i] && !stall && !r) begin
            total++;
            if (wait_cnt[i] > N - 1) begin
              bad++;
              $display("FAIL wait_bound client %0d: waited=%0d limit=%0d", i, wait_cnt[i], N - 1);
            end
          end
        end
      end
    end
  end

  initial begin
    logic [N-1:0] e, r, keep;
    logic         s;
    mptr    = 0;
    reset   = 1'b1;
    stall   = 1'b0;
    request = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    @(posedge clock);
    #1;

    // Reset holds grant low even with requests present.
    drive('1, 1'b0, 1'b1, "reset_quiet", e);
    drive(32'h0000_0010, 1'b0, 1'b1, "reset_quiet2", e);

    // Single request granted in the same cycle; pointer then sits at 5.
    drive(32'h0000_0010, 1'b0, 1'b0, "single_req", e);
    drive(32'h0000_0018, 1'b0, 1'b0, "wrap_search", e);
    drive(32'h0000_0010, 1'b0, 1'b0, "after_wrap", e);
    drive('0, 1'b0, 1'b0, "idle", e);

    // Back to ptr=0, then all requests held: full rotation plus wrap.
    drive('1, 1'b0, 1'b1, "reset_again", e);
    for (int i = 0; i < N + 3; i++) drive('1, 1'b0, 1'b0, "rotate_all", e);

    // Stall freezes grant and pointer.
    for (int i = 0; i < 3; i++) drive('1, 1'b1, 1'b0, "stall", e);
    drive('1, 1'b0, 1'b0, "post_stall", e);
    drive('1, 1'b0, 1'b0, "post_stall2", e);

    // Single active requester granted every non-stalled cycle.
    for (int i = 0; i < 4; i++) drive(32'h0000_0400, (i == 2), 1'b0, "lone_req", e);

    // Steer pointer to 17, then reset mid-operation.
    drive(32'h0001_0000, 1'b0, 1'b0, "to_ptr17", e);
    drive('1, 1'b0, 1'b1, "mid_reset", e);
    drive(32'h8000_0001, 1'b0, 1'b0, "after_reset", e);
    drive(32'h8000_0001, 1'b0, 1'b0, "after_reset2", e);
    drive(32'h8000_0001, 1'b0, 1'b0, "after_reset3", e);

    // Randomized: requests held until granted, 20% stall.
    r = '0;
    for (int c = 0; c < 2000; c++) begin
      s = ($urandom_range(0, 99) < 20);
      if (c == 900) begin
        drive(r, s, 1'b1, "rand_reset", e);
        continue;
      end
      drive(r, s, 1'b0, "random", e);
      keep = $urandom();
      r = (r & ~e) | (r & e & keep) | (($urandom() & $urandom()));
    end

    drive('0, 1'b0, 1'b0, "drain", e);
    @(negedge clock);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
